// File: rtl/fm_radio_pkg.sv
// Shared FM radio definitions: fixed-point format, demod gain and the
// quantize/dequantize helpers used by the discriminator and qarctan stages.
package fm_radio_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BITS       = 10;

  // Demodulator gain, already quantized (758).
  localparam logic [DATA_WIDTH-1:0] GAIN = 32'h0000_02F6;

  // pi/4 and 3*pi/4 in the same fixed-point format, used by qarctan.
  localparam logic signed [DATA_WIDTH-1:0] QUAD_ONE   = 32'sd804;
  localparam logic signed [DATA_WIDTH-1:0] QUAD_THREE = 32'sd2412;

  localparam logic signed [DATA_WIDTH-1:0] DEQ_BIAS =
    DATA_WIDTH'((64'd1 << BITS) - 64'd1);

  // Integer to fixed point.
  function automatic logic signed [DATA_WIDTH-1:0] quantize(
    input logic signed [DATA_WIDTH-1:0] v
  );
    return v <<< BITS;
  endfunction

  // Fixed point to integer, rounding toward zero.
  function automatic logic signed [DATA_WIDTH-1:0] dequantize(
    input logic signed [DATA_WIDTH-1:0] v
  );
    logic signed [DATA_WIDTH-1:0] biased;
    biased = v[DATA_WIDTH-1] ? v + DEQ_BIAS : v;
    return biased >>> BITS;
  endfunction

endpackage

// File: rtl/fm_demodulate_cmult.sv
// Combinational conjugate multiply: p = conj(a) * b, low DATA_WIDTH bits.
// Ports:
//   a_real/a_imag  previous sample
//   b_real/b_imag  current sample
//   p_real_c       a_r*b_r + a_i*b_i (wraps on overflow)
//   p_imag_c       a_r*b_i - a_i*b_r (wraps on overflow)
module fm_demodulate_cmult
  import fm_radio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = fm_radio_pkg::DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a_real,
  input  logic signed [DATA_WIDTH-1:0] a_imag,
  input  logic signed [DATA_WIDTH-1:0] b_real,
  input  logic signed [DATA_WIDTH-1:0] b_imag,
  output logic signed [DATA_WIDTH-1:0] p_real_c,
  output logic signed [DATA_WIDTH-1:0] p_imag_c
);

  // Products and sums kept at DATA_WIDTH: only the low word is wanted.
  assign p_real_c = (a_real * b_real) + (a_imag * b_imag);
  assign p_imag_c = (a_real * b_imag) - (a_imag * b_real);

endmodule

// File: rtl/fm_demodulate.sv
// FM discriminator front half. Pops one I/Q sample from a show-ahead FIFO,
// forms conj(prev)*cur, hands the dequantized (x,y) pair to qarctan, waits
// for the angle, scales it by the demod gain and pushes it to the audio FIFO.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   iq_empty           input FIFO empty; iq_real/iq_imag valid when 0
//   iq_real, iq_imag   current sample
//   iq_rd_en           input FIFO pop, one-cycle pulse per sample
//   demod_data_valid   one-cycle start pulse to qarctan
//   x, y               conj-product, dequantized; stable until angle_done
//   angle_in           qarctan result
//   angle_done         qarctan done strobe (angle_in valid that cycle only)
//   out_full           output FIFO full
//   out_wr_en          output FIFO push, one-cycle pulse per sample
//   out_din            scaled demod sample
module fm_demodulate #(
  parameter int unsigned            DATA_WIDTH = fm_radio_pkg::DATA_WIDTH,
  parameter int unsigned            BITS       = fm_radio_pkg::BITS,
  parameter logic [DATA_WIDTH-1:0]  GAIN       = DATA_WIDTH'(fm_radio_pkg::GAIN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iq_empty,
  input  logic [DATA_WIDTH-1:0] iq_real,
  input  logic [DATA_WIDTH-1:0] iq_imag,
  output logic                  iq_rd_en,
  output logic                  demod_data_valid,
  output logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] angle_in,
  input  logic                  angle_done,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din
);

  import fm_radio_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_ISSUE,
    S_WAIT_ANGLE,
    S_SCALE,
    S_WRITE
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] GAIN_S = GAIN;
  localparam logic signed [DATA_WIDTH-1:0] BIAS   =
    DATA_WIDTH'((64'd1 << BITS) - 64'd1);

  // Dequantize at this instance's width/format, rounding toward zero.
  function automatic logic signed [DATA_WIDTH-1:0] deq(
    input logic signed [DATA_WIDTH-1:0] v
  );
    logic signed [DATA_WIDTH-1:0] biased;
    biased = v[DATA_WIDTH-1] ? v + BIAS : v;
    return biased >>> BITS;
  endfunction

  state_t state, state_d;

  logic signed [DATA_WIDTH-1:0] cur_real,  cur_real_d;
  logic signed [DATA_WIDTH-1:0] cur_imag,  cur_imag_d;
  logic signed [DATA_WIDTH-1:0] prev_real, prev_real_d;
  logic signed [DATA_WIDTH-1:0] prev_imag, prev_imag_d;
  logic signed [DATA_WIDTH-1:0] angle,     angle_d;
  logic        [DATA_WIDTH-1:0] x_d, y_d, out_din_d;
  logic                         iq_rd_en_d, demod_data_valid_d, out_wr_en_d;

  logic signed [DATA_WIDTH-1:0] prod_real_c, prod_imag_c;
  logic signed [DATA_WIDTH-1:0] scaled_c;

  // conj(prev) * cur
  fm_demodulate_cmult #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmult (
    .a_real   (prev_real),
    .a_imag   (prev_imag),
    .b_real   (cur_real),
    .b_imag   (cur_imag),
    .p_real_c (prod_real_c),
    .p_imag_c (prod_imag_c)
  );

  // Gain product, low word only.
  assign scaled_c = GAIN_S * angle;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      cur_real         <= '0;
      cur_imag         <= '0;
      prev_real        <= '0;
      prev_imag        <= '0;
      angle            <= '0;
      x                <= '0;
      y                <= '0;
      out_din          <= '0;
      iq_rd_en         <= 1'b0;
      demod_data_valid <= 1'b0;
      out_wr_en        <= 1'b0;
    end else begin
      state            <= state_d;
      cur_real         <= cur_real_d;
      cur_imag         <= cur_imag_d;
      prev_real        <= prev_real_d;
      prev_imag        <= prev_imag_d;
      angle            <= angle_d;
      x                <= x_d;
      y                <= y_d;
      out_din          <= out_din_d;
      iq_rd_en         <= iq_rd_en_d;
      demod_data_valid <= demod_data_valid_d;
      out_wr_en        <= out_wr_en_d;
    end
  end

  // Next-state and next-register values. Strobes are registered, so each
  // one is visible in the cycle after the decision that raises it: iq_rd_en
  // during MULT, demod_data_valid during ISSUE, out_wr_en in the first IDLE
  // cycle after WRITE. A new pop can therefore never coincide with a push.
  always_comb begin
    state_d            = state;
    cur_real_d         = cur_real;
    cur_imag_d         = cur_imag;
    prev_real_d        = prev_real;
    prev_imag_d        = prev_imag;
    angle_d            = angle;
    x_d                = x;
    y_d                = y;
    out_din_d          = out_din;
    iq_rd_en_d         = 1'b0;
    demod_data_valid_d = 1'b0;
    out_wr_en_d        = 1'b0;

    case (state)
      S_IDLE: begin
        if (!iq_empty) begin
          cur_real_d = iq_real;
          cur_imag_d = iq_imag;
          iq_rd_en_d = 1'b1;
          state_d    = S_MULT;
        end
      end

      S_MULT: begin
        x_d                = deq(prod_real_c);
        y_d                = deq(prod_imag_c);
        prev_real_d        = cur_real;
        prev_imag_d        = cur_imag;
        demod_data_valid_d = 1'b1;
        state_d            = S_ISSUE;
      end

      S_ISSUE: begin
        state_d = S_WAIT_ANGLE;
      end

      // No timeout: qarctan always answers.
      S_WAIT_ANGLE: begin
        if (angle_done) begin
          angle_d = angle_in;
          state_d = S_SCALE;
        end
      end

      S_SCALE: begin
        out_din_d = deq(scaled_c);
        state_d   = S_WRITE;
      end

      S_WRITE: begin
        if (!out_full) begin
          out_wr_en_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fm_demodulate.sv
// Bench for fm_demodulate: FIFO and qarctan stub driven from tasks, results
// compared with an arithmetic model of the discriminator.
module tb_fm_demodulate;

  logic        clk = 1'b0;
  logic        reset;
  logic        iq_empty;
  logic [31:0] iq_real, iq_imag;
  logic        iq_rd_en;
  logic        demod_data_valid;
  logic [31:0] x, y;
  logic [31:0] angle_in;
  logic        angle_done;
  logic        out_full;
  logic        out_wr_en;
  logic [31:0] out_din;

  int checks = 0;
  int errors = 0;
  int prev_re = 0;
  int prev_im = 0;

  localparam int GAIN_I = 758;

  always #5 clk = ~clk;

  fm_demodulate dut (
    .clk              (clk),
    .reset            (reset),
    .iq_empty         (iq_empty),
    .iq_real          (iq_real),
    .iq_imag          (iq_imag),
    .iq_rd_en         (iq_rd_en),
    .demod_data_valid (demod_data_valid),
    .x                (x),
    .y                (y),
    .angle_in         (angle_in),
    .angle_done       (angle_done),
    .out_full         (out_full),
    .out_wr_en        (out_wr_en),
    .out_din          (out_din)
  );

  // Reference model: integer division truncates toward zero.
  function automatic int m_deq(int v);
    return v / 1024;
  endfunction

  function automatic int m_re(int pr, int pi, int cr, int ci);
    return int'(longint'(pr) * longint'(cr) + longint'(pi) * longint'(ci));
  endfunction

  function automatic int m_im(int pr, int pi, int cr, int ci);
    return int'(longint'(pr) * longint'(ci) - longint'(pi) * longint'(cr));
  endfunction

  function automatic int m_out(int ang);
    return m_deq(int'(longint'(GAIN_I) * longint'(ang)));
  endfunction

  // Push one sample, answer as qarctan after dly (>=1) cycles, optionally
  // hold out_full for full_cyc cycles in WRITE; report what was observed.
  task automatic run_sample(input int re, input int im, input int ang,
                            input int dly, input int full_cyc,
                            output int ox, output int oy, output int odin,
                            output int n_rd, output int n_ddv, output int n_wr,
                            output bit to, output bit xy_hold,
                            output bit din_hold, output bit overlap);
    bit seen;
    logic [31:0] d0;
    ox = 0; oy = 0; odin = 0; n_rd = 0; n_ddv = 0; n_wr = 0;
    to = 0; xy_hold = 1; din_hold = 1; overlap = 0; seen = 0;
    iq_real  = re;
    iq_imag  = im;
    iq_empty = 1'b0;
    out_full = (full_cyc > 0);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (iq_rd_en && out_wr_en) overlap = 1;
      if (out_wr_en) n_wr++;
      if (iq_rd_en) begin n_rd++; iq_empty = 1'b1; end
      if (demod_data_valid) begin n_ddv++; ox = x; oy = y; seen = 1; end
    end
    if (!seen) begin
      to = 1; iq_empty = 1'b1; out_full = 1'b0;
      return;
    end
    for (int c = 0; c < dly; c++) begin
      @(posedge clk); #1;
      if (x !== 32'(ox) || y !== 32'(oy)) xy_hold = 0;
      if (demod_data_valid) n_ddv++;
      if (iq_rd_en) n_rd++;
      if (out_wr_en) n_wr++;
    end
    angle_in   = ang;
    angle_done = 1'b1;
    @(posedge clk); #1;
    angle_done = 1'b0;
    angle_in   = $urandom;
    if (full_cyc > 0) begin
      @(posedge clk); #1;
      d0 = out_din;
      for (int c = 0; c < full_cyc; c++) begin
        @(posedge clk); #1;
        if (out_wr_en) n_wr++;
        if (out_din !== d0) din_hold = 0;
      end
      out_full = 1'b0;
    end
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (iq_rd_en && out_wr_en) overlap = 1;
      if (iq_rd_en) n_rd++;
      if (out_wr_en) begin n_wr++; odin = out_din; seen = 1; end
    end
    if (!seen) to = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_wr_en) n_wr++;
      if (iq_rd_en) n_rd++;
      if (demod_data_valid) n_ddv++;
    end
  endtask

  task automatic test_reset();
    int strobes;
    reset = 1'b0; iq_empty = 1'b1; iq_real = '0; iq_imag = '0;
    angle_in = '0; angle_done = 1'b0; out_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (x !== 32'd0 || y !== 32'd0) begin
      errors++; $display("FAIL reset_xy: x=%0d y=%0d required 0 0", $signed(x), $signed(y));
    end
    checks++;
    if (out_din !== 32'd0) begin
      errors++; $display("FAIL reset_out_din: got %0d required 0", $signed(out_din));
    end
    checks++;
    if ({iq_rd_en, demod_data_valid, out_wr_en} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b required 000", {iq_rd_en, demod_data_valid, out_wr_en});
    end
    @(posedge clk); #2;
    reset = 1'b1;
    strobes = 0;
    repeat (6) begin
      @(posedge clk); #1;
      strobes += int'(iq_rd_en) + int'(demod_data_valid) + int'(out_wr_en);
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL idle_empty_strobes: got %0d required 0", strobes);
    end
    prev_re = 0; prev_im = 0;
  endtask

  // Directed samples with hand-computed outputs.
  task automatic test_basic();
    int t_re[3]  = '{1024, 0, 1024};
    int t_im[3]  = '{0, 1024, 0};
    int t_ang[3] = '{32'h648, 32'h324, -804};
    int t_out[3] = '{1190, 595, -595};
    int ox, oy, od, nr, nd, nw;
    bit to, xh, dh, ov;
    for (int i = 0; i < 3; i++) begin
      int ex, ey;
      ex = m_deq(m_re(prev_re, prev_im, t_re[i], t_im[i]));
      ey = m_deq(m_im(prev_re, prev_im, t_re[i], t_im[i]));
      run_sample(t_re[i], t_im[i], t_ang[i], 2, 0, ox, oy, od, nr, nd, nw, to, xh, dh, ov);
      prev_re = t_re[i]; prev_im = t_im[i];
      checks++;
      if (to) begin errors++; $display("FAIL basic%0d_timeout: got 1 required 0", i); end
      checks++;
      if (ox != ex || oy != ey) begin
        errors++; $display("FAIL basic%0d_xy: got %0d,%0d required %0d,%0d", i, ox, oy, ex, ey);
      end
      checks++;
      if (od != t_out[i]) begin
        errors++; $display("FAIL basic%0d_out_din: got %0d required %0d", i, od, t_out[i]);
      end
      checks++;
      if (nr != 1 || nd != 1 || nw != 1) begin
        errors++; $display("FAIL basic%0d_pulses: rd/ddv/wr got %0d/%0d/%0d required 1/1/1", i, nr, nd, nw);
      end
      checks++;
      if (!xh || ov) begin
        errors++; $display("FAIL basic%0d_hold: xy_hold=%0b overlap=%0b required 1 0", i, xh, ov);
      end
    end
  endtask

  // Output back-pressure, slow qarctan, spurious angle_done while idle.
  task automatic test_stalls();
    int ox, oy, od, nr, nd, nw;
    bit to, xh, dh, ov;
    for (int i = 0; i < 2; i++) begin
      int re, im, ang, ex, ey, eo;
      re  = int'($urandom_range(0, 8000)) - 4000;
      im  = int'($urandom_range(0, 8000)) - 4000;
      ang = int'($urandom_range(0, 6434)) - 3217;
      if (i == 1) begin
        logic [31:0] sx, sy;
        int junk;
        sx = x; sy = y; junk = 0;
        repeat (4) begin
          angle_in = $urandom; angle_done = 1'b1;
          @(posedge clk); #1;
          angle_done = 1'b0;
          junk += int'(demod_data_valid) + int'(out_wr_en) + int'(iq_rd_en);
        end
        checks++;
        if (junk != 0 || x !== sx || y !== sy) begin
          errors++; $display("FAIL spurious_done: strobes=%0d x=%0d y=%0d required 0 %0d %0d",
                             junk, $signed(x), $signed(y), $signed(sx), $signed(sy));
        end
      end
      ex = m_deq(m_re(prev_re, prev_im, re, im));
      ey = m_deq(m_im(prev_re, prev_im, re, im));
      eo = m_out(ang);
      run_sample(re, im, ang, (i == 0) ? 1 : 50, (i == 0) ? 20 : 0,
                 ox, oy, od, nr, nd, nw, to, xh, dh, ov);
      prev_re = re; prev_im = im;
      checks++;
      if (to) begin errors++; $display("FAIL stall%0d_timeout: got 1 required 0", i); end
      checks++;
      if (ox != ex || oy != ey || !xh) begin
        errors++; $display("FAIL stall%0d_xy: got %0d,%0d hold=%0b required %0d,%0d hold=1", i, ox, oy, xh, ex, ey);
      end
      checks++;
      if (od != eo || !dh) begin
        errors++; $display("FAIL stall%0d_out_din: got %0d stable=%0b required %0d stable=1", i, od, dh, eo);
      end
      checks++;
      if (nr != 1 || nd != 1 || nw != 1 || ov) begin
        errors++; $display("FAIL stall%0d_pulses: rd/ddv/wr/ov got %0d/%0d/%0d/%0b required 1/1/1/0", i, nr, nd, nw, ov);
      end
    end
  endtask

  // Reset while waiting for the angle: nothing written, prev cleared.
  task automatic test_reset_abort();
    int ox, oy, od, nr, nd, nw, wr, ang;
    bit to, xh, dh, ov, seen;
    iq_real = 32'd5000; iq_imag = -32'sd7000; iq_empty = 1'b0; out_full = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (iq_rd_en) iq_empty = 1'b1;
      if (demod_data_valid) seen = 1;
    end
    iq_empty = 1'b1;
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_issue_timeout: got 0 pulses required 1"); end
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (x !== 32'd0 || y !== 32'd0 || out_wr_en !== 1'b0) begin
      errors++; $display("FAIL abort_in_reset: x=%0d y=%0d wr=%b required 0 0 0", $signed(x), $signed(y), out_wr_en);
    end
    angle_in = 32'h648; angle_done = 1'b1;
    @(posedge clk); #1;
    angle_done = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    wr = 0;
    repeat (8) begin
      @(posedge clk); #1;
      wr += int'(out_wr_en) + int'(demod_data_valid);
    end
    checks++;
    if (wr != 0) begin errors++; $display("FAIL abort_no_write: strobes got %0d required 0", wr); end
    prev_re = 0; prev_im = 0;
    ang = int'($urandom_range(0, 6434)) - 3217;
    run_sample(1024, 0, ang, 3, 0, ox, oy, od, nr, nd, nw, to, xh, dh, ov);
    prev_re = 1024; prev_im = 0;
    checks++;
    if (to || ox != 0 || oy != 0) begin
      errors++; $display("FAIL abort_prev_cleared: timeout=%0b x=%0d y=%0d required 0 0 0", to, ox, oy);
    end
    checks++;
    if (od != m_out(ang) || nw != 1) begin
      errors++; $display("FAIL abort_resume_out: got %0d writes=%0d required %0d writes=1", od, nw, m_out(ang));
    end
  endtask

  // Full-range random samples, including products that wrap.
  task automatic test_random();
    int ox, oy, od, nr, nd, nw;
    bit to, xh, dh, ov;
    for (int i = 0; i < 30; i++) begin
      int re, im, ang, ex, ey, eo;
      if (i % 2 == 0) begin
        re = int'($urandom); im = int'($urandom);
      end else begin
        re = int'($urandom_range(0, 2097152)) - 1048576;
        im = int'($urandom_range(0, 2097152)) - 1048576;
      end
      ang = int'($urandom_range(0, 6434)) - 3217;
      ex = m_deq(m_re(prev_re, prev_im, re, im));
      ey = m_deq(m_im(prev_re, prev_im, re, im));
      eo = m_out(ang);
      run_sample(re, im, ang, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                 ox, oy, od, nr, nd, nw, to, xh, dh, ov);
      prev_re = re; prev_im = im;
      checks++;
      if (to || ox != ex || oy != ey || !xh) begin
        errors++; $display("FAIL rand%0d_xy: got %0d,%0d to=%0b hold=%0b required %0d,%0d to=0 hold=1",
                           i, ox, oy, to, xh, ex, ey);
      end
      checks++;
      if (od != eo || !dh) begin
        errors++; $display("FAIL rand%0d_out_din: got %0d stable=%0b required %0d stable=1", i, od, dh, eo);
      end
      checks++;
      if (nr != 1 || nd != 1 || nw != 1 || ov) begin
        errors++; $display("FAIL rand%0d_pulses: rd/ddv/wr/ov got %0d/%0d/%0d/%0b required 1/1/1/0", i, nr, nd, nw, ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
